// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan feeder.
//   state_t     : handshake FSM states (IDLE, CONVERT, LOAD)
//   SEG_*       : segment codes, bit order gfedcba, active-high
//   BCD_DIGITS  : number of displayed digits
//   BIN_W       : width of the binary input value
//   MAX_VAL     : largest value that fits in BCD_DIGITS digits
//   bcd_to_seg  : nibble to segment code; nibbles above 9 give blank
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LOAD    = 2'd2
    } state_t;

    localparam int BCD_DIGITS = 4;
    localparam int BIN_W      = 14;

    localparam logic [BIN_W-1:0] MAX_VAL = 14'd9999;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one iteration per clock.
//   clk, rst : clock and synchronous active-high reset
//   start    : load bin and begin a conversion (ignored mid-conversion only
//              by the caller; a start always restarts)
//   bin      : binary value to convert
//   done     : high during the cycle whose clock edge performs the final
//              iteration; bcd is complete from the following cycle on
//   bcd      : four BCD nibbles, digit 3 in the top nibble
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin,
    output logic                      done,
    output logic [BCD_DIGITS*4-1:0]   bcd
);

    localparam int SR_W = BCD_DIGITS * 4 + BIN_W;
    localparam logic [3:0] LAST_ITER = 4'(BIN_W - 1);

    logic [SR_W-1:0] sr_q, sr_d, adj;
    logic [3:0]      iter_q, iter_d;
    logic            active_q, active_d;

    always_comb begin
        adj      = sr_q;
        sr_d     = sr_q;
        iter_d   = iter_q;
        active_d = active_q;
        // Add-3 correction on every BCD nibble before the shift.
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (adj[BIN_W + 4*i +: 4] >= 4'd5) begin
                adj[BIN_W + 4*i +: 4] = adj[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        if (start) begin
            sr_d     = {{(BCD_DIGITS*4){1'b0}}, bin};
            iter_d   = 4'd0;
            active_d = 1'b1;
        end else if (active_q) begin
            sr_d   = {adj[SR_W-2:0], 1'b0};
            iter_d = iter_q + 4'd1;
            if (iter_q == LAST_ITER) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q     <= '0;
            iter_q   <= 4'd0;
            active_q <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            iter_q   <= iter_d;
            active_q <= active_d;
        end
    end

    assign done = active_q && (iter_q == LAST_ITER);
    assign bcd  = sr_q[SR_W-1:BIN_W];

endmodule

// File: rtl/seg_scan_feeder.sv
// Accepts a 14-bit value, converts it to four BCD digits and scans them out
// as time-multiplexed seven-segment codes.
//   clk_clk, reset_reset : clock, synchronous active-high reset
//   value_data/valid/ready : input value handshake
//   seg_code  : segment code gfedcba for the currently enabled digit
//   digit_en  : one-hot digit select, bit 0 = rightmost digit
//   busy      : conversion in progress (CONVERT or LOAD)
//   overflow  : last accepted value was above 9999 (digits show dashes)
// Optional macro SEG_ACTIVE_LOW_EN: invert seg_code and digit_en at the output
// registers for common-anode boards.
//
// Handshake: a value transfers on a rising edge where value_valid and
// value_ready are both high. value_ready is high only in IDLE; value_valid
// presented while busy is ignored, and the source must keep it asserted with
// stable data until it sees value_ready.
module seg_scan_feeder
    import seg_pkg::*;
#(
    parameter int SCAN_DIV      = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [BIN_W-1:0]  value_data,
    input  logic              value_valid,
    output logic              value_ready,
    output logic [6:0]        seg_code,
    output logic [3:0]        digit_en,
    output logic              busy,
    output logic              overflow
);

    localparam int PW = $clog2(SCAN_DIV);

`ifdef SEG_ACTIVE_LOW_EN
    localparam logic [6:0] SEG_POL = 7'h7F;
    localparam logic [3:0] EN_POL  = 4'hF;
`else
    localparam logic [6:0] SEG_POL = 7'h00;
    localparam logic [3:0] EN_POL  = 4'h0;
`endif

    // Handshake FSM and display register
    state_t                   state_q;
    logic                     ready_q, busy_q, ovf_q, pend_ovf_q;
    logic [BCD_DIGITS*4-1:0]  disp_q;
    logic                     disp_dash_q;   // display holds the dash pattern
    logic                     accept;
    logic                     bcd_done;
    logic [BCD_DIGITS*4-1:0]  bcd;

    assign accept = value_valid && ready_q;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .start (accept),
        .bin   (value_data),
        .done  (bcd_done),
        .bcd   (bcd)
    );

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            pend_ovf_q  <= 1'b0;
            disp_q      <= '0;
            disp_dash_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        pend_ovf_q <= (value_data > MAX_VAL);
                        state_q    <= CONVERT;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                CONVERT: begin
                    if (bcd_done) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    disp_q      <= bcd;
                    disp_dash_q <= pend_ovf_q;
                    ovf_q       <= pend_ovf_q;
                    state_q     <= IDLE;
                    ready_q     <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Scanner: the segment register is only reloaded at a slot boundary, so a
    // display update mid-slot shows up from the next slot without tearing.
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d, idx_nxt;
    logic [6:0]    seg_q, seg_d, seg_raw;
    logic [3:0]    en_q, en_d;
    logic [3:0]    dig_nib;
    logic          upper_zero;

    always_comb begin
        idx_nxt    = idx_q + 2'd1;
        presc_d    = presc_q + PW'(1);
        idx_d      = idx_q;
        seg_d      = seg_q;
        en_d       = en_q;
        dig_nib    = disp_q[{idx_nxt, 2'b00} +: 4];
        // This digit and all digits above it are zero.
        upper_zero = ((disp_q >> {idx_nxt, 2'b00}) == '0);
        if (disp_dash_q) begin
            seg_raw = SEG_DASH;
        end else if (BLANK_LEADING && (idx_nxt != 2'd0) && upper_zero) begin
            seg_raw = SEG_BLANK;
        end else begin
            seg_raw = bcd_to_seg(dig_nib);
        end
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = idx_nxt;
            seg_d   = seg_raw ^ SEG_POL;
            en_d    = (4'b0001 << idx_nxt) ^ EN_POL;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
            seg_q   <= SEG_0 ^ SEG_POL;
            en_q    <= 4'b0001 ^ EN_POL;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            en_q    <= en_d;
        end
    end

    assign value_ready = ready_q;
    assign busy        = busy_q;
    assign overflow    = ovf_q;
    assign seg_code    = seg_q;
    assign digit_en    = en_q;

endmodule

// File: tb/tb_seg_scan_feeder.sv
module tb_seg_scan_feeder;

    localparam int SCAN_DIV = 4;

`ifdef SEG_ACTIVE_LOW_EN
    localparam logic [6:0] SEG_POL = 7'h7F;
    localparam logic [3:0] EN_POL  = 4'hF;
`else
    localparam logic [6:0] SEG_POL = 7'h00;
    localparam logic [3:0] EN_POL  = 4'h0;
`endif

    // ---------------- clock / reset ----------------
    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic [13:0] value_data;
    logic        value_valid;

    always #5 clk_clk = ~clk_clk;

    logic       value_ready, busy, overflow;
    logic [6:0] seg_code;
    logic [3:0] digit_en;
    logic       value_ready_nb, busy_nb, overflow_nb;
    logic [6:0] seg_code_nb;
    logic [3:0] digit_en_nb;

    seg_scan_feeder #(.SCAN_DIV(SCAN_DIV), .BLANK_LEADING(1'b1)) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .value_data  (value_data),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .seg_code    (seg_code),
        .digit_en    (digit_en),
        .busy        (busy),
        .overflow    (overflow)
    );

    seg_scan_feeder #(.SCAN_DIV(SCAN_DIV), .BLANK_LEADING(1'b0)) dut_nb (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .value_data  (value_data),
        .value_valid (value_valid),
        .value_ready (value_ready_nb),
        .seg_code    (seg_code_nb),
        .digit_en    (digit_en_nb),
        .busy        (busy_nb),
        .overflow    (overflow_nb)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int pow10(input int k);
        case (k)
            0:       return 1;
            1:       return 10;
            2:       return 100;
            default: return 1000;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int val, input bit ovf, input int k, input bit blank);
        int hi;
        if (ovf) return 7'b1000000;
        hi = val / pow10(k);
        if (blank && k > 0 && hi == 0) return 7'b0000000;
        case (hi % 10)
            0:       return 7'b0111111;
            1:       return 7'b0000110;
            2:       return 7'b1011011;
            3:       return 7'b1001111;
            4:       return 7'b1100110;
            5:       return 7'b1101101;
            6:       return 7'b1111101;
            7:       return 7'b0000111;
            8:       return 7'b1111111;
            default: return 7'b1101111;
        endcase
    endfunction

    // Values accepted but not yet loaded into the display.
    logic [13:0] exp_q[$];

    bit m_valid = 0;   // model initialised by a reset edge
    int m_cyc;         // edges since the last reset edge
    int m_timer;       // cycles until the pending value reaches the display
    int m_val;         // display content (binary)
    bit m_ovf;
    int m_show_val;    // content latched for the current scan slot
    bit m_show_ovf;

    // Outputs are compared at the falling edge; the model then advances by
    // the coming rising edge using the inputs that edge will sample.
    always @(negedge clk_clk) begin
        int idx;
        logic [13:0] v;
        if (m_valid) begin
            idx = (m_cyc / SCAN_DIV) % 4;
            check("digit_en",    32'(digit_en),    32'((4'b0001 << idx) ^ EN_POL));
            check("seg_code",    32'(seg_code),    32'(exp_seg(m_show_val, m_show_ovf, idx, 1'b1) ^ SEG_POL));
            check("digit_en_nb", 32'(digit_en_nb), 32'((4'b0001 << idx) ^ EN_POL));
            check("seg_code_nb", 32'(seg_code_nb), 32'(exp_seg(m_show_val, m_show_ovf, idx, 1'b0) ^ SEG_POL));
            check("value_ready", 32'(value_ready), 32'(m_timer == 0));
            check("busy",        32'(busy),        32'(m_timer != 0));
            check("overflow",    32'(overflow),    32'(m_ovf));
            check("ready_nb",    32'(value_ready_nb), 32'(m_timer == 0));
            check("busy_nb",     32'(busy_nb),     32'(m_timer != 0));
            check("overflow_nb", 32'(overflow_nb), 32'(m_ovf));
        end
        if (reset_reset) begin
            m_valid    = 1;
            m_cyc      = 0;
            m_timer    = 0;
            m_val      = 0;
            m_ovf      = 0;
            m_show_val = 0;
            m_show_ovf = 0;
            exp_q.delete();
        end else if (m_valid) begin
            m_cyc++;
            // Slot boundary sees the display as it stood before this edge.
            if (m_cyc % SCAN_DIV == 0) begin
                m_show_val = m_val;
                m_show_ovf = m_ovf;
            end
            if (m_timer != 0) begin
                m_timer--;
                if (m_timer == 0 && exp_q.size() > 0) begin
                    v     = exp_q.pop_front();
                    m_ovf = (v > 14'd9999);
                    m_val = m_ovf ? 0 : int'(v);
                end
            end else if (value_valid) begin
                exp_q.push_back(value_data);
                m_timer = 15;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    // Presents v and holds valid until the accepting edge; returns just after it.
    task automatic send(input logic [13:0] v);
        int n;
        n = 0;
        value_data  = v;
        value_valid = 1'b1;
        while (!value_ready && n < 200) begin
            @(posedge clk_clk);
            #1;
            n++;
        end
        if (!value_ready) check("ready_timeout", 32'(value_ready), 32'd1);
        @(posedge clk_clk);
        #1;
        value_valid = 1'b0;
    endtask

    localparam int SETTLE = 16 + 3 * 4 * SCAN_DIV;

    initial begin
        int n;
        logic [13:0] v;
        reset_reset = 1'b1;
        value_valid = 1'b0;
        value_data  = '0;
        idle(2);
        reset_reset = 1'b0;

        // Reset scan of 0000
        check("rst_ready", 32'(value_ready), 32'd1);
        check("rst_seg",   32'(seg_code),    32'(7'b0111111 ^ SEG_POL));
        idle(20);

        // 1234 with latency check
        send(14'd1234);
        n = 0;
        while (!value_ready && n < 100) begin
            @(posedge clk_clk);
            #1;
            n++;
        end
        check("ready_low_cycles", 32'(n), 32'd15);
        idle(SETTLE);

        send(14'd7);
        idle(SETTLE);

        send(14'd12000);
        idle(SETTLE);
        check("ovf_set", 32'(overflow), 32'd1);
        send(14'd9999);
        idle(SETTLE);
        check("ovf_clear", 32'(overflow), 32'd0);

        // 5678 held while busy with 42
        send(14'd42);
        send(14'd5678);
        check("held_busy_after_accept", 32'(busy), 32'd1);
        idle(SETTLE);

        // Reset mid-conversion
        send(14'd4321);
        idle(7);
        reset_reset = 1'b1;
        idle(1);
        reset_reset = 1'b0;
        check("abort_ready", 32'(value_ready), 32'd1);
        check("abort_busy",  32'(busy),        32'd0);
        check("abort_en",    32'(digit_en),    32'(4'b0001 ^ EN_POL));
        idle(SETTLE);

        // Randomised values and gaps
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       v = 14'($urandom_range(10000, 16383));
                1:       v = 14'($urandom_range(0, 99));
                default: v = 14'($urandom_range(0, 9999));
            endcase
            send(v);
            idle($urandom_range(0, 40));
        end
        idle(SETTLE);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
